// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_pkg                                                       |
// | Purpose  : Shared button indices, timing defaults, ms-to-cycles helper.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package btn_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int DEF_CLK_HZ           = 25_000_000;
  localparam int DEF_DEBOUNCE_MS      = 10;
  localparam int DEF_REPEAT_DELAY_MS  = 500;
  localparam int DEF_REPEAT_PERIOD_MS = 100;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debounce_channel                                              |
// | Purpose  : One button: 2-flop sync, counter debounce, press/release      |
// |            pulses; auto-repeat when BUTTON_CONDITIONER_AUTOREPEAT_EN.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 4
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 10,
  parameter int REPEAT_PERIOD = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int            CW        = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] c_CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_toggle;

  // The counter clears on toggle, so it never has to wrap.
  always_comb begin
    w_toggle  = (s2_q != level_q) && (cnt_q == c_CNT_MAX);
    level_d   = level_q ^ w_toggle;
    release_d = w_toggle & level_q;
    if ((s2_q == level_q) || w_toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] c_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] c_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          first_q, first_d;
  logic          w_rep_hit;

  // first_q selects the initial hold delay; afterwards the shorter period.
  always_comb begin
    rcnt_d    = rcnt_q;
    first_d   = first_q;
    w_rep_hit = 1'b0;
    if (!level_q || w_toggle) begin
      rcnt_d  = '0;
      first_d = 1'b1;
    end else if (rcnt_q == (first_q ? c_DELAY_LAST : c_PERIOD_LAST)) begin
      rcnt_d    = '0;
      first_d   = 1'b0;
      w_rep_hit = 1'b1;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end
    press_d = (w_toggle & ~level_q) | w_rep_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      first_q <= 1'b1;
    end else begin
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
    end
  end
`else
  always_comb begin
    press_d = w_toggle & ~level_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : button_conditioner                                            |
// | Purpose  : NUM_BTN independent debounced buttons with press/release      |
// |            pulses; BUTTON_CONDITIONER_AUTOREPEAT_EN adds hold-repeat.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN          = 5,
  parameter int CLK_HZ           = DEF_CLK_HZ,
  parameter int DEBOUNCE_MS      = DEF_DEBOUNCE_MS
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_MS  = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_PERIOD_MS = DEF_REPEAT_PERIOD_MS
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

  generate
    if (DB_CYCLES < 2) begin : g_db_check
      $error("button_conditioner: DB_CYCLES must be at least 2");
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      debounce_channel #(
        .DB_CYCLES     (DB_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY  (ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS)),
        .REPEAT_PERIOD (ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS))
`endif
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_i     (btn_raw[i]),
        .level_o   (btn_level[i]),
        .press_o   (btn_press[i]),
        .release_o (btn_release[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_button_conditioner                                         |
// | Purpose  : Directed + random bench with a run-length reference model.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;

  localparam int N   = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .NUM_BTN          (N),
    .CLK_HZ           (1000),
    .DEBOUNCE_MS      (DB)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_MS  (RD),
    .REPEAT_PERIOD_MS (RP)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw seen two edges late; level flips after DB
  // consecutive disagreeing samples; repeat pulses from hold time.
  logic [N-1:0] pipe[$];
  int           run  [N];
  int           hold [N];
  logic [N-1:0] m_level   = '0;
  logic [N-1:0] m_press   = '0;
  logic [N-1:0] m_release = '0;

  initial begin
    logic [N-1:0] dly;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        m_level = '0; m_press = '0; m_release = '0;
        for (int i = 0; i < N; i++) begin run[i] = 0; hold[i] = 0; end
      end else begin
        dly = pipe.pop_front();
        pipe.push_back(btn_raw);
        m_press = '0; m_release = '0;
        for (int i = 0; i < N; i++) begin
          run[i] = (dly[i] != m_level[i]) ? run[i] + 1 : 0;
          if (run[i] == DB) begin
            run[i]     = 0;
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin m_press[i] = 1'b1; hold[i] = 0; end
            else m_release[i] = 1'b1;
          end else if (m_level[i]) begin
            hold[i]++;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            if (hold[i] >= RD && ((hold[i] - RD) % RP) == 0) m_press[i] = 1'b1;
`endif
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_level",   btn_level,   m_level);
      chk("model_press",   btn_press,   m_press);
      chk("model_release", btn_release, m_release);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Returns just after the n-th upcoming edge (first upcoming edge = 1).
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with all buttons down: outputs stay clear.
    repeat (3) step();
    @(negedge clk);
    chk("rst_level",   btn_level,   5'b00000);
    chk("rst_press",   btn_press,   5'b00000);
    chk("rst_release", btn_release, 5'b00000);
    step();
    rst_n = 1'b1;
    wait_edges(5);
    chk("rst_rel_level_e5", btn_level, 5'b00000);
    @(negedge clk);
    chk("rst_rel_level_e6",   btn_level,   5'b11111);
    chk("rst_rel_press_e6",   btn_press,   5'b11111);
    chk("rst_rel_release_e6", btn_release, 5'b00000);
    @(negedge clk);
    chk("rst_rel_press_e7", btn_press, 5'b00000);

    step(); btn_raw = '0;
    repeat (10) step();

    // Clean press on channel C.
    btn_raw[0] = 1'b1;
    wait_edges(5);
    chk("press_level_k4", btn_level, 5'b00000);
    @(negedge clk);
    chk("press_level_k5", btn_level, 5'b00001);
    chk("press_pulse_k5", btn_press, 5'b00001);
    @(negedge clk);
    chk("press_pulse_k6", btn_press, 5'b00000);

    // 3-cycle glitch on channel L is rejected.
    step(); btn_raw[2] = 1'b1;
    step(); step(); step();
    btn_raw[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("glitch_level2", {4'b0, btn_level[2]}, 5'b00000);
      chk("glitch_press2", {4'b0, btn_press[2]}, 5'b00000);
    end

    // Bounce 1-0-1 then held: count restarts at the last bounce.
    step(); btn_raw[2] = 1'b1;
    step(); btn_raw[2] = 1'b0;
    step(); btn_raw[2] = 1'b1;
    wait_edges(5);
    chk("bounce_level_k4", {4'b0, btn_level[2]}, 5'b00000);
    @(negedge clk);
    chk("bounce_level_k5", {4'b0, btn_level[2]}, 5'b00001);
    chk("bounce_press_k5", {4'b0, btn_press[2]}, 5'b00001);

    // Release of channel C.
    step(); btn_raw[0] = 1'b0;
    wait_edges(5);
    chk("release_level_k4", {4'b0, btn_level[0]}, 5'b00001);
    @(negedge clk);
    chk("release_level_k5", {4'b0, btn_level[0]}, 5'b00000);
    chk("release_pulse_k5", btn_release, 5'b00001);
    step(); btn_raw[2] = 1'b0;
    repeat (8) step();

    // Reset while channel R counter sits at 3.
    btn_raw[3] = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level",   btn_level,   5'b00000);
    chk("midrst_press",   btn_press,   5'b00000);
    chk("midrst_release", btn_release, 5'b00000);
    step(); step();
    rst_n = 1'b1;
    wait_edges(5);
    chk("midrst_level_e5", btn_level, 5'b00000);
    @(negedge clk);
    chk("midrst_level_e6", btn_level, 5'b01000);
    chk("midrst_press_e6", btn_press, 5'b01000);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    // Hold BTNU: pulses at t0, t0+10, t0+13, t0+16.
    step(); btn_raw[1] = 1'b1;
    wait_edges(6);
    chk("rep_t0", {4'b0, btn_press[1]}, 5'b00001);
    for (int off = 1; off <= 17; off++) begin
      @(negedge clk);
      chk("rep_offset", {4'b0, btn_press[1]},
          (off == 10 || off == 13 || off == 16) ? 5'b00001 : 5'b00000);
    end
    step(); btn_raw[1] = 1'b0;
    repeat (20) step();
`endif

    // Randomised toggling with occasional resets, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    step(); btn_raw = '0;
    repeat (12) step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
